// File: rtl/serial_modn_unit.sv
// Serial residue engine: result = x mod m, consuming K operand bits per clock MSB-first (Horner).
// A start/ready/done handshake runs IDLE -> RUN -> DONE; m == 0 completes at once with err set.
module serial_modn_unit #(
    parameter int W  = 64,
    parameter int K  = 2,
    parameter int MW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  x,
    input  logic [MW-1:0] m,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [MW-1:0] result,
    output logic          err
);

    localparam int N  = (W + K - 1) / K;
    localparam int SW = N * K;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Handshake: a request is taken on any edge where ready && start; done is high
    // for exactly one cycle, and result/err hold until the next accepted request.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [SW-1:0]   r_sh;
    logic [MW-1:0]   r_m;
    logic [MW:0]     r_rem;
    logic [CW-1:0]   r_cnt;
    logic [MW-1:0]   r_result;
    logic            r_err;
    logic [MW:0]     w_acc;
    logic [MW:0]     w_rem_next;
    logic            w_last;
    logic            w_mzero;

    assign w_last  = (r_cnt == LAST);
    assign w_mzero = (m == '0);

    // r < M holds on entry to every step, so the doubled value never needs more than MW+1 bits.
    always_comb begin
        w_acc = r_rem;
        for (int i = 0; i < K; i++) begin
            w_acc = {w_acc[MW-1:0], r_sh[SW-1-i]};
            if (w_acc >= {1'b0, r_m}) begin
                w_acc = w_acc - {1'b0, r_m};
            end
        end
        w_rem_next = w_acc;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_mzero ? S_DONE : S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sh     <= '0;
            r_m      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Zero padding on the MSB side leaves the residue unchanged.
                        r_sh  <= SW'(x);
                        r_m   <= m;
                        r_rem <= '0;
                        r_cnt <= '0;
                        r_err <= w_mzero;
                        if (w_mzero) begin
                            r_result <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_sh  <= r_sh << K;
                    r_rem <= w_rem_next;
                    if (w_last) begin
                        r_result <= w_rem_next[MW-1:0];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready  = (r_state == S_IDLE);
    assign busy   = (r_state == S_RUN) || (r_state == S_DONE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign err    = r_err;

endmodule

// File: doc/serial_modn_unit.md
Name: serial_modn_unit

Overview:
- Generalised, parametrised successor to the team's fixed 64-bit serial mod-3 engine.
- Computes R = X mod M for a W-bit unsigned operand X and a runtime-selectable MW-bit modulus M.
- Consumes K bits of X per clock, MSB-first (Horner), using a start/ready/done handshake and synchronous reset.
- Used wherever a low-area residue of a wide word is needed: checksums, residue checking, bucket/index hashing.

Parameters:
W, 64, operand width in bits (W >= 1)
K, 2, bits consumed per cycle (1 <= K <= W)
MW, 8, modulus/result width in bits (MW >= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when ready=1
x  input  W  operand; captured on the accepting edge
m  input  MW  modulus; captured on the accepting edge
ready  output  1  high only in IDLE
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse
result  output  MW  X mod M; valid from done until the next accepted start
err  output  1  set with done when captured M == 0; held with result

Behaviour:
- Reset: rst high at an edge forces state=IDLE. Also clears ready=1, busy=0, done=0, result=0, err=0 and the internal remainder, counter and shift register. rst overrides every other input, including mid-RUN (operation abandoned, no done).
- States: IDLE, RUN, DONE.
- IDLE: ready=1.
  - Edge with start=1: latch x into a shift register, zero-padded on the MSB side to N*K bits, where N = ceil(W/K).
  - Same edge: latch m, remainder r=0, counter=0, err=0.
  - If latched m == 0: go to DONE with err=1, result=0.
  - Otherwise go to RUN.
  - start=0: stay.
- RUN: each edge takes the top K bits of the shift register as chunk c (MSB of chunk first) and shifts the register left by K.
  - Unrolled K times: r = 2r + bit; if r >= M then r = r - M.
  - Invariant r < M holds throughout. Internal width is MW+1 bits; no overflow for any M in 1..2^MW-1.
  - The edge where counter reaches N-1 writes result=r_final, done=1, state=DONE. Otherwise counter++.
- DONE: lasts exactly one cycle.
  - done=1, busy=1, ready=0.
  - Next edge: done=0, state=IDLE. result and err hold.
- Latency: done is high in the cycle after the N-th edge following the accepting edge; for M == 0, after the 1st edge.
- Throughput: one operation per N+1 cycles (N+2 including the IDLE accept cycle, for back-to-back requests).
- start while ready=0 is ignored (not queued).
- x and m changes after acceptance have no effect.
- M == 1 gives result 0, err=0. M > X gives result X.
- result and err change only on a completing edge or on rst. Between operations they hold the last value.
- Leading zero padding when W mod K != 0 must not alter the result.

Test Plan:
1. Defaults: x=64'd100, m=3, start pulse → done exactly 32 cycles after the accepting edge, result=1, err=0. ready returns high the following cycle.
2. Defaults: x=64'hFFFF_FFFF_FFFF_FFFF, run back-to-back with m=3, then m=7, then m=255 → results 0, 1, 0. The second start asserted while busy is ignored and must be re-issued once ready=1.
3. Instance W=7, K=2, MW=4: x=7'h7F, m=5 → result=2 after N=4 RUN cycles. Then x=7'd3, m=9 → result=3 (M > X).
4. m=0 with any x → done pulse after 1 edge, err=1, result=0. Next op with m=1, x=12345 → result=0, err cleared.
5. rst asserted at RUN cycle 10 of a defaults op → next cycle ready=1, busy=0, done=0, result=0, and no done pulse appears afterwards. A new op (x=64'd10, m=4) then yields 2.
6. Randomised, at least 1000 ops across K∈{1,2,3,8}: x, m random, m≠0 → result == x % m. done is a single-cycle pulse and latency is exactly ceil(W/K) every time.
